// File: rtl/button_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, edge-first debounce FSM,
// press/release/hold-repeat pulses and a debounced level per channel.
module button_debounce_multi #(
   parameter int unsigned NUM_BTNS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 5,
   parameter int unsigned HOLD_CYCLES     = 50,
   parameter int unsigned REPEAT_CYCLES   = 10,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BTNS-1:0] btn_in,
   input  logic [NUM_BTNS-1:0] btn_en,
   output logic [NUM_BTNS-1:0] press_pulse,
   output logic [NUM_BTNS-1:0] release_pulse,
   output logic [NUM_BTNS-1:0] hold_pulse,
   output logic [NUM_BTNS-1:0] btn_level
);

   localparam int unsigned MAX_HR  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_HR > DEBOUNCE_CYCLES) ? MAX_HR : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0] L_DEB     = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] L_HOLD    = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] L_REP     = CW'(REPEAT_CYCLES);
   localparam logic [CW-1:0] L_HOLD_M1 = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] L_REP_M1  = CW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRESS_LOCK, HELD, REL_LOCK} state_t;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
      logic [1:0]    r_sync;
      state_t        r_state, w_state_nxt;
      logic [CW-1:0] r_lock, w_lock_nxt;
      logic [CW-1:0] r_hold, w_hold_nxt;
      logic          r_rep, w_rep_nxt;
      logic          w_press, w_rel, w_hold;
      logic          r_press, r_rel, r_hold_p, r_level;
      logic          w_sync;
      logic [CW-1:0] w_target, w_target_m1;

      assign w_sync = r_sync[1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_sync   <= '0;
            r_state  <= IDLE;
            r_lock   <= '0;
            r_hold   <= '0;
            r_rep    <= 1'b0;
            r_press  <= 1'b0;
            r_rel    <= 1'b0;
            r_hold_p <= 1'b0;
            r_level  <= 1'b0;
         end else begin
            r_sync   <= {r_sync[0], btn_in[g]};
            r_state  <= w_state_nxt;
            r_lock   <= w_lock_nxt;
            r_hold   <= w_hold_nxt;
            r_rep    <= w_rep_nxt;
            r_press  <= w_press & btn_en[g];
            r_rel    <= w_rel & btn_en[g];
            r_hold_p <= w_hold & btn_en[g];
            r_level  <= (w_state_nxt == PRESS_LOCK) || (w_state_nxt == HELD);
         end
      end

      // After the first hold pulse the counter restarts from 0 and targets the repeat period
      assign w_target    = r_rep ? L_REP : L_HOLD;
      assign w_target_m1 = r_rep ? L_REP_M1 : L_HOLD_M1;

      always_comb begin
         w_state_nxt = r_state;
         w_lock_nxt  = r_lock;
         w_hold_nxt  = r_hold;
         w_rep_nxt   = r_rep;
         w_press     = 1'b0;
         w_rel       = 1'b0;
         w_hold      = 1'b0;
         case (r_state)
            IDLE: begin
               if (w_sync) begin
                  w_state_nxt = PRESS_LOCK;
                  w_press     = 1'b1;
                  w_lock_nxt  = '0;
                  w_hold_nxt  = '0;
                  w_rep_nxt   = 1'b0;
               end
            end
            PRESS_LOCK: begin
               if (r_lock == L_DEB) begin
                  w_state_nxt = HELD;
                  w_lock_nxt  = '0;
               end else begin
                  w_lock_nxt = r_lock + 1'b1;
               end
               if (r_hold < w_target) w_hold_nxt = r_hold + 1'b1;
            end
            HELD: begin
               if (!w_sync) begin
                  w_state_nxt = REL_LOCK;
                  w_rel       = 1'b1;
                  w_lock_nxt  = '0;
                  w_hold_nxt  = '0;
                  w_rep_nxt   = 1'b0;
               end else if (r_hold == w_target_m1) begin
                  w_hold = 1'b1;
                  if (REPEAT_EN) begin
                     w_hold_nxt = '0;
                     w_rep_nxt  = 1'b1;
                  end else begin
                     w_hold_nxt = r_hold + 1'b1;
                  end
               end else if (r_hold < w_target) begin
                  w_hold_nxt = r_hold + 1'b1;
               end
            end
            REL_LOCK: begin
               if (r_lock == L_DEB) begin
                  w_state_nxt = IDLE;
                  w_lock_nxt  = '0;
               end else begin
                  w_lock_nxt = r_lock + 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end

      assign press_pulse[g]   = r_press;
      assign release_pulse[g] = r_rel;
      assign hold_pulse[g]    = r_hold_p;
      assign btn_level[g]     = r_level;
   end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed self-checking bench for button_debounce_multi (D=5, H=50, R=10),
// with a second instance built with REPEAT_EN=0.
module tb_button_debounce_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn_in = '0;
   logic [3:0] btn_en = '1;
   logic [3:0] press, rel, hold, level;
   logic [3:0] press2, rel2, hold2, level2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   button_debounce_multi #(.NUM_BTNS(4), .DEBOUNCE_CYCLES(5), .HOLD_CYCLES(50),
                           .REPEAT_CYCLES(10), .REPEAT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_en(btn_en),
      .press_pulse(press), .release_pulse(rel), .hold_pulse(hold), .btn_level(level));

   button_debounce_multi #(.NUM_BTNS(4), .DEBOUNCE_CYCLES(5), .HOLD_CYCLES(50),
                           .REPEAT_CYCLES(10), .REPEAT_EN(1'b0)) dut_norep (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_en(btn_en),
      .press_pulse(press2), .release_pulse(rel2), .hold_pulse(hold2), .btn_level(level2));

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_in = '0; btn_en = '1;
      step(3);
      n_checks++; if (press !== 4'b0) begin n_fail++; $display("FAIL reset_press: got %b expected 0000", press); end
      n_checks++; if (rel !== 4'b0) begin n_fail++; $display("FAIL reset_release: got %b expected 0000", rel); end
      n_checks++; if (hold !== 4'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0000", hold); end
      n_checks++; if (level !== 4'b0) begin n_fail++; $display("FAIL reset_level: got %b expected 0000", level); end
      n_checks++; if ({press2, rel2, hold2, level2} !== 16'h0) begin n_fail++; $display("FAIL reset_norep: got %h expected 0000", {press2, rel2, hold2, level2}); end
      rst = 1'b0;
      step(3);
   endtask

   task automatic test_clean_press();
      btn_in = 4'b0001;
      step(1);
      n_checks++; if (press !== 4'b0000) begin n_fail++; $display("FAIL clean_press_k: got %b expected 0000", press); end
      step(1);
      n_checks++; if (press !== 4'b0000) begin n_fail++; $display("FAIL clean_press_k1: got %b expected 0000", press); end
      step(1);
      n_checks++; if (press !== 4'b0001) begin n_fail++; $display("FAIL clean_press_k2: got %b expected 0001", press); end
      n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL clean_level: got %b expected 0001", level); end
      n_checks++; if ({rel, hold} !== 8'h0) begin n_fail++; $display("FAIL clean_other: got %h expected 00", {rel, hold}); end
      step(1);
      n_checks++; if (press !== 4'b0000) begin n_fail++; $display("FAIL clean_press_width: got %b expected 0000", press); end
      n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL clean_level_hold: got %b expected 0001", level); end
      step(10);
      btn_in = 4'b0000;
      step(2);
      n_checks++; if (rel !== 4'b0000) begin n_fail++; $display("FAIL clean_rel_early: got %b expected 0000", rel); end
      step(1);
      n_checks++; if (rel !== 4'b0001) begin n_fail++; $display("FAIL clean_rel: got %b expected 0001", rel); end
      n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL clean_rel_level: got %b expected 0000", level); end
      step(1);
      n_checks++; if (rel !== 4'b0000) begin n_fail++; $display("FAIL clean_rel_width: got %b expected 0000", rel); end
      step(10);
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      int np, nr, nh;
      pat = 5'b10101;
      np = 0; nr = 0; nh = 0;
      for (int i = 0; i < 5; i++) begin
         btn_in[1] = pat[i];
         step(1);
         np += int'(press[1]); nr += int'(rel[1]); nh += int'(hold[1]);
      end
      btn_in[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         np += int'(press[1]); nr += int'(rel[1]); nh += int'(hold[1]);
      end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL bounce_press_count: got %0d expected 1", np); end
      n_checks++; if (nr != 0) begin n_fail++; $display("FAIL bounce_press_rel_count: got %0d expected 0", nr); end
      n_checks++; if (level[1] !== 1'b1) begin n_fail++; $display("FAIL bounce_level_high: got %b expected 1", level[1]); end
      np = 0; nr = 0;
      pat = 5'b01010;
      for (int i = 0; i < 5; i++) begin
         btn_in[1] = pat[i];
         step(1);
         np += int'(press[1]); nr += int'(rel[1]); nh += int'(hold[1]);
      end
      btn_in[1] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         np += int'(press[1]); nr += int'(rel[1]); nh += int'(hold[1]);
      end
      n_checks++; if (nr != 1) begin n_fail++; $display("FAIL bounce_rel_count: got %0d expected 1", nr); end
      n_checks++; if (np != 0) begin n_fail++; $display("FAIL bounce_rel_press_count: got %0d expected 0", np); end
      n_checks++; if (nh != 0) begin n_fail++; $display("FAIL bounce_hold_count: got %0d expected 0", nh); end
      n_checks++; if (level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_level_low: got %b expected 0", level[1]); end
   endtask

   task automatic test_hold_repeat();
      logic exp_h, exp_h2;
      btn_in = 4'b0001;
      step(3);
      n_checks++; if (press !== 4'b0001) begin n_fail++; $display("FAIL hold_press: got %b expected 0001", press); end
      for (int i = 1; i <= 99; i++) begin
         step(1);
         exp_h  = (i >= 50) && ((i - 50) % 10 == 0);
         exp_h2 = (i == 50);
         n_checks++; if (hold[0] !== exp_h) begin n_fail++; $display("FAIL hold_repeat P+%0d: got %b expected %b", i, hold[0], exp_h); end
         n_checks++; if (hold2[0] !== exp_h2) begin n_fail++; $display("FAIL hold_norep P+%0d: got %b expected %b", i, hold2[0], exp_h2); end
         if (i == 97) btn_in = 4'b0000;
      end
      step(1);
      n_checks++; if (rel[0] !== 1'b1) begin n_fail++; $display("FAIL hold_rel P+100: got %b expected 1", rel[0]); end
      n_checks++; if (hold[0] !== 1'b0) begin n_fail++; $display("FAIL hold_rel_wins P+100: got %b expected 0", hold[0]); end
      n_checks++; if (hold2[0] !== 1'b0) begin n_fail++; $display("FAIL hold_norep P+100: got %b expected 0", hold2[0]); end
      step(10);
   endtask

   task automatic test_release_boundary();
      logic exp_h, exp_r;
      btn_in = 4'b1000;
      step(3);
      n_checks++; if (press !== 4'b1000) begin n_fail++; $display("FAIL bound_press: got %b expected 1000", press); end
      for (int i = 1; i <= 70; i++) begin
         step(1);
         exp_h = (i == 50);
         exp_r = (i == 60);
         n_checks++; if (hold[3] !== exp_h) begin n_fail++; $display("FAIL bound_hold P+%0d: got %b expected %b", i, hold[3], exp_h); end
         n_checks++; if (rel[3] !== exp_r) begin n_fail++; $display("FAIL bound_rel P+%0d: got %b expected %b", i, rel[3], exp_r); end
         if (i == 57) btn_in = 4'b0000;
      end
      step(5);
   endtask

   task automatic test_enable();
      int np, nr, nh;
      logic exp_h, exp_r;
      np = 0; nr = 0; nh = 0;
      btn_en = 4'b1011;
      btn_in = 4'b0100;
      step(3);
      n_checks++; if (level[2] !== 1'b1) begin n_fail++; $display("FAIL en_level_high: got %b expected 1", level[2]); end
      np += int'(press[2]);
      for (int i = 1; i <= 63; i++) begin
         step(1);
         np += int'(press[2]); nr += int'(rel[2]); nh += int'(hold[2]);
         if (i == 57) btn_in = 4'b0000;
      end
      n_checks++; if (level[2] !== 1'b0) begin n_fail++; $display("FAIL en_level_low: got %b expected 0", level[2]); end
      n_checks++; if (np + nr + nh != 0) begin n_fail++; $display("FAIL en_suppress: got %0d pulses expected 0", np + nr + nh); end
      step(10);
      // re-enable mid-hold: only the scheduled repeats after re-enable appear
      btn_in = 4'b0100;
      step(3);
      n_checks++; if (press[2] !== 1'b0) begin n_fail++; $display("FAIL reen_press: got %b expected 0", press[2]); end
      for (int i = 1; i <= 75; i++) begin
         step(1);
         exp_h = (i == 60) || (i == 70);
         exp_r = (i == 75);
         n_checks++; if (hold[2] !== exp_h) begin n_fail++; $display("FAIL reen_hold P+%0d: got %b expected %b", i, hold[2], exp_h); end
         n_checks++; if (rel[2] !== exp_r) begin n_fail++; $display("FAIL reen_rel P+%0d: got %b expected %b", i, rel[2], exp_r); end
         if (i == 55) btn_en = 4'b1111;
         if (i == 72) btn_in = 4'b0000;
      end
      step(10);
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_h, exp_r;
      btn_in = 4'b1111;
      step(3);
      n_checks++; if (press !== 4'b1111) begin n_fail++; $display("FAIL sim_press: got %b expected 1111", press); end
      n_checks++; if (level !== 4'b1111) begin n_fail++; $display("FAIL sim_level: got %b expected 1111", level); end
      for (int i = 1; i <= 56; i++) begin
         step(1);
         exp_h = (i == 50) ? 4'b1111 : 4'b0000;
         exp_r = (i == 55) ? 4'b1111 : 4'b0000;
         n_checks++; if (hold !== exp_h) begin n_fail++; $display("FAIL sim_hold P+%0d: got %b expected %b", i, hold, exp_h); end
         n_checks++; if (rel !== exp_r) begin n_fail++; $display("FAIL sim_rel P+%0d: got %b expected %b", i, rel, exp_r); end
         if (i == 52) btn_in = 4'b0000;
      end
      step(10);
   endtask

   task automatic test_reset_mid();
      btn_in = 4'b0001;
      step(3);
      n_checks++; if (press !== 4'b0001) begin n_fail++; $display("FAIL rstmid_press: got %b expected 0001", press); end
      step(20);
      n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL rstmid_level_before: got %b expected 0001", level); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL rstmid_level_async: got %b expected 0000", level); end
      n_checks++; if ({press, rel, hold} !== 12'h0) begin n_fail++; $display("FAIL rstmid_pulses: got %h expected 000", {press, rel, hold}); end
      step(2);
      rst = 1'b0;
      step(2);
      n_checks++; if (press !== 4'b0000) begin n_fail++; $display("FAIL rstmid_repress_early: got %b expected 0000", press); end
      step(1);
      n_checks++; if (press !== 4'b0001) begin n_fail++; $display("FAIL rstmid_repress: got %b expected 0001", press); end
      btn_in = 4'b0000;
      step(15);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold_repeat();
      test_release_boundary();
      test_enable();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debounce_multi.md
# button_debounce_multi

Multi-channel button conditioner: synchronises, debounces and edge-decodes `NUM_BTNS` raw push buttons, giving per-channel press, release and hold/auto-repeat pulses plus a clean debounced level. It is the next generation of the single-button edge-first debounce and sits between board push buttons and the display control logic (mode, scroll and jump-step commands).

## Interface
- `NUM_BTNS`, 4, number of independent channels (≥1)
- `DEBOUNCE_CYCLES`, 5, lockout length after any accepted edge (≥1)
- `HOLD_CYCLES`, 50, cycles from press pulse to first hold pulse (must exceed `DEBOUNCE_CYCLES`+1)
- `REPEAT_CYCLES`, 10, hold-pulse period after the first hold pulse (≥1)
- `REPEAT_EN`, 1, 1 = auto-repeat while held; 0 = single hold pulse only

- `clk` in 1 system clock, all logic on rising edge
- `rst` in 1 asynchronous, active-high reset
- `btn_in` in NUM_BTNS raw, asynchronous, noisy button inputs (1 = pressed)
- `btn_en` in NUM_BTNS per-channel pulse enable; 0 suppresses all pulses, FSM keeps running
- `press_pulse` out NUM_BTNS 1-cycle pulse on accepted press
- `release_pulse` out NUM_BTNS 1-cycle pulse on accepted release
- `hold_pulse` out NUM_BTNS 1-cycle pulse on long-press and each repeat
- `btn_level` out NUM_BTNS debounced state (1 = pressed)

## Operation
- Per channel: 2-flop synchroniser (reset 0), then independent FSM; channels never interact.
- States: IDLE (released, stable), PRESS_LOCK, HELD, REL_LOCK. Reset → IDLE, all counters 0, all outputs 0.
- IDLE: sync=1 → PRESS_LOCK, `press_pulse`=1 (if enabled), lock counter and hold counter cleared.
- PRESS_LOCK: input ignored; lock counter increments each cycle; when it equals `DEBOUNCE_CYCLES` → HELD, counter cleared. Lockout thus spans `DEBOUNCE_CYCLES`+1 cycles.
- HELD: sync=0 → REL_LOCK, `release_pulse`=1 (if enabled), hold counter cleared. Otherwise wait for hold timing.
- REL_LOCK: input ignored for `DEBOUNCE_CYCLES`+1 cycles, then → IDLE.
- `btn_level` = 1 in PRESS_LOCK and HELD, 0 in IDLE and REL_LOCK.
- Hold counter runs from the press pulse through PRESS_LOCK and HELD; saturates, never wraps. Width = $clog2(max(HOLD_CYCLES, REPEAT_CYCLES, DEBOUNCE_CYCLES))+1.
- First `hold_pulse` when hold count reaches `HOLD_CYCLES`; with `REPEAT_EN`=1, counter reloads and pulses every `REPEAT_CYCLES` while in HELD; with 0, counter holds, no further pulses.
- Release in HELD cancels pending hold/repeat in the same cycle; `release_pulse` and `hold_pulse` never coincide (release wins).
- `btn_en`=0: pulses forced 0, `btn_level` still valid, state and counters advance normally; re-enabling mid-hold yields the next scheduled repeat, no catch-up pulse.
- All outputs registered.

## Timing
- Press latency: `btn_in` high sampled at edge k → `press_pulse` high for the cycle after edge k+2.
- Release latency: same 3-edge path from HELD.
- Press pulse at edge P → earliest release-edge evaluation at edge P+`DEBOUNCE_CYCLES`+2.
- First hold pulse at edge P+`HOLD_CYCLES`; repeats at P+`HOLD_CYCLES`+n·`REPEAT_CYCLES`.
- Glitches shorter than 2 cycles may be missed; any glitch inside a lockout is ignored.
- `rst` asserted mid-operation: every output and state 0 immediately (async); after deassert a still-pressed button yields a fresh press pulse after 3 edges.

## Test plan
- Clean press, D=5: `btn_in[0]` high at edge 10 → `press_pulse[0]` only after edge 12 for 1 cycle, `btn_level[0]`=1, no other channel active.
- Bounce: `btn_in[1]` toggles every cycle for 5 cycles after first high, then steady high → exactly one `press_pulse[1]`; bouncy release likewise → exactly one `release_pulse[1]`.
- Hold/repeat, H=50, R=10: hold 100 cycles → `hold_pulse` at P+50, P+60, …, P+90 (5 pulses); `REPEAT_EN`=0 → only P+50.
- Release on repeat boundary (released so HELD sees 0 at P+60) → `release_pulse`, no `hold_pulse` at P+60.
- `btn_en[2]`=0 during full press/hold/release → no pulses, `btn_level[2]` tracks; all four channels pressed simultaneously → four identical independent pulse trains.
- `rst` pulsed while held in HELD → all outputs 0 at once; button still high after deassert → new `press_pulse` 3 edges later.
